tx_compensation: RTL and testbench
==================================

TX_COMPENSATION -- requirements
Module: tx_compensation

Interface
REQ-001 SHALL have parameter DW, default 16: sample and coefficient width in bits (two's complement).
REQ-002 SHALL have parameter DEPTH, default 1024: coefficient entries per frame (power of two).
REQ-003 SHALL have parameter MEM_FILE, default "tx_comp.mem": hex file that initialises the coefficient table.
REQ-004 SHALL use one clock and an asynchronous active-high reset; ports as below.
REQ-005 clk  in  1  the single clock; all flops on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 tdata_s  in  DW  input sample.
REQ-008 tvalid_s / tlast_s  in  1 each  input beat valid / last beat of frame.
REQ-009 tready_s  out  1  input accepted when high together with tvalid_s.
REQ-010 tdata_m  out  DW  compensated sample.
REQ-011 tvalid_m / tlast_m  out  1 each  output valid / last.
REQ-012 tready_m  in  1  downstream ready.
REQ-013 haddr_s  in  32; htrans_s  in  2; hwrite_s  in  1; hsize_s  in  3; hwdata_s  in  32; hready_s  in  1: AHB slave address/data phase.
REQ-014 hrdata_s  out  32; hreadyout_s  out  1; hresp_s  out  1: AHB slave response.

Function
REQ-015 SHALL output tdata_m = tdata_s + coeff[idx] for every accepted beat: a pre-compensating add, the inverse of the receive-side subtraction.
REQ-016 idx SHALL start at 0, increment per accepted beat, return to 0 after a tlast_s beat, and wrap from DEPTH-1 to 0 without tlast_s.
REQ-017 SHALL be a two-stage pipeline: stage 1 registers sample, last, and synchronous RAM read of coeff[idx]; stage 2 registers the sum. Latency is 2 cycles from acceptance to tvalid_m with no stall.
REQ-018 Pipeline advance = !tvalid_m || tready_m; tready_s SHALL equal advance. When advance is low, both stages and the RAM read address SHALL hold. No beat is lost or duplicated.
REQ-019 tdata_m and tlast_m SHALL remain stable while tvalid_m && !tready_m.
REQ-020 tlast_m SHALL accompany the sample that entered with tlast_s.
REQ-021 AHB map: byte 0x000-(2*DEPTH-2) holds coefficients at halfword index haddr_s[log2(DEPTH):1] in hwdata_s/hrdata_s[DW-1:0]. 0x800 is CTRL, bit0 BYPASS (reset 0). 0x804 is FRAMES (RO), a 32-bit wrapping count of output tlast_m beats. Other addresses read 0 and ignore writes.
REQ-022 A transfer SHALL be captured in the address phase when hready_s && htrans_s[1]. The write SHALL take effect in the data phase using hwdata_s. Read data SHALL be valid in the data phase. hreadyout_s SHALL stay 1 (zero wait) for OKAY responses.
REQ-023 hsize_s > 3'b010 SHALL produce the two-cycle ERROR response: cycle 1 hresp_s=1, hreadyout_s=0; cycle 2 hresp_s=1, hreadyout_s=1. No write occurs.
REQ-024 An AHB write and a stream read of the same coefficient in the same cycle SHALL be read-first: the stream uses the old value.
REQ-025 With BYPASS=1, tdata_m SHALL equal the input sample, with latency and handshake unchanged. A BYPASS change SHALL apply to beats entering stage 2 after the write.

Reset
REQ-026 On reset, tvalid_m, tlast_m, tdata_m, hresp_s, hrdata_s, idx, CTRL, FRAMES and the pipeline valids SHALL be 0, and hreadyout_s SHALL be 1. Coefficient RAM SHALL retain contents.
REQ-027 Reset mid-frame SHALL discard in-flight beats. The next accepted beat after release uses idx 0.

Configuration
REQ-028 Macro TX_COMP_SATURATE_EN, when defined, SHALL clamp the sum to [-2^(DW-1), 2^(DW-1)-1]. When undefined, the sum SHALL wrap modulo 2^DW.

Verification
REQ-029 Coefficient c[i]=i, input 1024-beat frame of 100, tready_m=1 -> outputs 100..1123, tlast_m on beat 1023, first tvalid_m 2 cycles after first accept.
REQ-030 tready_m toggled with pseudo-random 50% duty over 3 frames -> output sequence identical to the no-stall run, FRAMES reads 3.
REQ-031 Input 0x7FF0 with coeff 0x0020 -> 0x7FFF with TX_COMP_SATURATE_EN, 0x8010 without.
REQ-032 AHB write 0x1234 to byte 0x010 in the same cycle as the stream reads idx 8 -> that beat uses the old coefficient, and the next frame's beat 8 uses 0x1234. A read-back of 0x010 returns 0x00001234.
REQ-033 AHB access with hsize_s=3'b011 -> two-cycle ERROR, coefficient unchanged. Write CTRL=1 -> output equals input.
REQ-034 Reset asserted at beat 500 of a frame -> tvalid_m=0 immediately. After release, the next beat is compensated with coeff[0].

Source files
------------

// File: rtl/tx_compensation.sv
// tx_compensation: stream pre-compensation tdata_m = tdata_s + coeff[idx], coefficients/CTRL/FRAMES on AHB.
// Latency 2 cycles; stall (!tready_m with tvalid_m) freezes both stages. TX_COMP_SATURATE_EN clamps the sum.
module tx_compensation #(
    parameter int    DW       = 16,
    parameter int    DEPTH    = 1024,
    parameter string MEM_FILE = "tx_comp.mem"
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] tdata_s,
    input  logic          tvalid_s,
    input  logic          tlast_s,
    output logic          tready_s,
    output logic [DW-1:0] tdata_m,
    output logic          tvalid_m,
    output logic          tlast_m,
    input  logic          tready_m,
    input  logic [31:0]   haddr_s,
    input  logic [1:0]    htrans_s,
    input  logic          hwrite_s,
    input  logic [2:0]    hsize_s,
    input  logic [31:0]   hwdata_s,
    input  logic          hready_s,
    output logic [31:0]   hrdata_s,
    output logic          hreadyout_s,
    output logic          hresp_s
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {AHB_OKAY, AHB_ERR1, AHB_ERR2} ahb_state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_COEF, SEL_CTRL, SEL_FRM} sel_t;

    logic [DW-1:0] r_ram [DEPTH];
    logic [AW-1:0] r_idx;
    logic          r_vld1, r_last1, r_vld2, r_last2;
    logic [DW-1:0] r_dat1, r_coef, r_dat2, r_ram_hrd;
    logic          r_bypass;
    logic [31:0]   r_frames, r_hreg;
    ahb_state_t    r_state;
    sel_t          r_wsel, r_rsel, w_sel;
    logic          r_wr_pend, r_hresp, r_hreadyout;
    logic [AW-1:0] r_waddr;
    logic          w_adv, w_acc, w_ahb_cap, w_err;
    logic [DW-1:0] w_sum;
    logic          w_unused;

    assign w_adv       = !r_vld2 || tready_m;
    assign w_acc       = w_adv && tvalid_s;
    assign tready_s    = w_adv;
    assign tvalid_m    = r_vld2;
    assign tdata_m     = r_dat2;
    assign tlast_m     = r_last2;
    assign w_ahb_cap   = hready_s && htrans_s[1];
    assign w_err       = hsize_s > 3'b010;
    assign hresp_s     = r_hresp;
    assign hreadyout_s = r_hreadyout;
    assign w_unused    = ^{htrans_s[0], hwdata_s[31:DW]};

`ifdef TX_COMP_SATURATE_EN
    logic [DW:0] w_sum_ext;
    always_comb begin
        w_sum_ext = {r_dat1[DW-1], r_dat1} + {r_coef[DW-1], r_coef};
        w_sum     = w_sum_ext[DW-1:0];
        if (w_sum_ext[DW] != w_sum_ext[DW-1])
            w_sum = w_sum_ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
`else
    assign w_sum = r_dat1 + r_coef;
`endif

    always_comb begin
        w_sel = SEL_NONE;
        if (haddr_s[31:AW+1] == '0)  w_sel = SEL_COEF;
        else if (haddr_s == 32'h800) w_sel = SEL_CTRL;
        else if (haddr_s == 32'h804) w_sel = SEL_FRM;
    end

    always_comb begin
        case (r_rsel)
            SEL_COEF:          hrdata_s = {{(32-DW){1'b0}}, r_ram_hrd};
            SEL_CTRL, SEL_FRM: hrdata_s = r_hreg;
            default:           hrdata_s = 32'h0;
        endcase
    end

    // Single-edge read and write: the stream read sees the pre-write coefficient.
    always @(posedge clk) begin
        if (w_adv)
            r_coef <= r_ram[r_idx];
        if (w_ahb_cap)
            r_ram_hrd <= r_ram[haddr_s[AW:1]];
        if (r_wr_pend && r_wsel == SEL_COEF)
            r_ram[r_waddr] <= hwdata_s[DW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx    <= '0;
            r_vld1   <= 1'b0;
            r_last1  <= 1'b0;
            r_dat1   <= '0;
            r_vld2   <= 1'b0;
            r_last2  <= 1'b0;
            r_dat2   <= '0;
            r_frames <= '0;
        end else begin
            if (w_adv) begin
                r_vld1  <= tvalid_s;
                r_dat1  <= tdata_s;
                r_last1 <= tlast_s && tvalid_s;
                r_vld2  <= r_vld1;
                r_last2 <= r_last1;
                r_dat2  <= r_bypass ? r_dat1 : w_sum;
            end
            if (w_acc)
                r_idx <= tlast_s ? '0 : r_idx + 1'b1;
            if (r_vld2 && tready_m && r_last2)
                r_frames <= r_frames + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= AHB_OKAY;
            r_hresp     <= 1'b0;
            r_hreadyout <= 1'b1;
            r_wr_pend   <= 1'b0;
            r_wsel      <= SEL_NONE;
            r_rsel      <= SEL_NONE;
            r_waddr     <= '0;
            r_hreg      <= '0;
            r_bypass    <= 1'b0;
        end else begin
            if (r_wr_pend && r_wsel == SEL_CTRL)
                r_bypass <= hwdata_s[0];
            r_wr_pend <= 1'b0;
            r_rsel    <= SEL_NONE;
            case (r_state)
                AHB_ERR1: begin
                    r_state     <= AHB_ERR2;
                    r_hreadyout <= 1'b1;
                end
                default: begin
                    r_state     <= AHB_OKAY;
                    r_hresp     <= 1'b0;
                    r_hreadyout <= 1'b1;
                    if (w_ahb_cap) begin
                        if (w_err) begin
                            r_state     <= AHB_ERR1;
                            r_hresp     <= 1'b1;
                            r_hreadyout <= 1'b0;
                        end else begin
                            r_wr_pend <= hwrite_s;
                            r_wsel    <= w_sel;
                            r_waddr   <= haddr_s[AW:1];
                            r_rsel    <= hwrite_s ? SEL_NONE : w_sel;
                            r_hreg    <= (w_sel == SEL_FRM) ? r_frames : {31'b0, r_bypass};
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tx_compensation.sv
// Bench for tx_compensation: vector table, scoreboard queue, hand-timed AHB/stream corner sequences.
module tb_tx_compensation;
    logic        clk, reset;
    logic [15:0] tdata_s, tdata_m;
    logic        tvalid_s, tlast_s, tready_s, tvalid_m, tlast_m, tready_m;
    logic [31:0] haddr_s, hwdata_s, hrdata_s;
    logic [1:0]  htrans_s;
    logic        hwrite_s, hready_s, hreadyout_s, hresp_s;
    logic [2:0]  hsize_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_mode = 0;
    bit lat_arm = 0;
    int first_vld_c = -1;
    logic [16:0] exp_q[$];
    bit stall_pend = 0;
    logic [16:0] stall_val;

    typedef struct {
        logic [15:0] din;
        logic [15:0] coef;
        logic [15:0] exp_wrap;
        logic [15:0] exp_sat;
    } vec_t;
    vec_t tbl[8];

    tx_compensation #(.DW(16), .DEPTH(1024), .MEM_FILE("")) dut (
        .clk(clk), .reset(reset),
        .tdata_s(tdata_s), .tvalid_s(tvalid_s), .tlast_s(tlast_s), .tready_s(tready_s),
        .tdata_m(tdata_m), .tvalid_m(tvalid_m), .tlast_m(tlast_m), .tready_m(tready_m),
        .haddr_s(haddr_s), .htrans_s(htrans_s), .hwrite_s(hwrite_s), .hsize_s(hsize_s),
        .hwdata_s(hwdata_s), .hready_s(hready_s),
        .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s), .hresp_s(hresp_s)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        tready_m = 1'b1;
        forever begin
            @(posedge clk); #1;
            tready_m = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pop and hold-while-stalled check.
    always @(negedge clk) begin
        if (reset) begin
            stall_pend = 0;
        end else begin
            if (stall_pend && tvalid_m)
                check("stall_hold", {tlast_m, tdata_m}, stall_val);
            stall_pend = tvalid_m && !tready_m;
            stall_val  = {tlast_m, tdata_m};
            if (lat_arm && tvalid_m && first_vld_c < 0)
                first_vld_c = cyc;
            if (tvalid_m && tready_m) begin
                if (exp_q.size() == 0)
                    check("unexpected_beat", {tlast_m, tdata_m}, 17'h1ffff);
                else
                    check("out_beat", {tlast_m, tdata_m}, exp_q.pop_front());
            end
        end
    end

    task automatic send_beat(input logic [15:0] d, input logic l, input logic [15:0] e, output int acc_c);
        bit done = 0;
        acc_c = -1;
        tvalid_s = 1'b1; tdata_s = d; tlast_s = l;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge clk);
            if (tready_s) begin
                acc_c = cyc;
                exp_q.push_back({l, e});
                done = 1;
            end
            @(posedge clk); #1;
        end
        tvalid_s = 1'b0; tlast_s = 1'b0;
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        haddr_s = a; htrans_s = 2'b10; hwrite_s = 1'b1; hsize_s = sz;
        @(posedge clk); #1;
        htrans_s = 2'b00; hwrite_s = 1'b0; hwdata_s = d;
        @(posedge clk); #1;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        haddr_s = a; htrans_s = 2'b10; hwrite_s = 1'b0; hsize_s = 3'b010;
        @(posedge clk); #1;
        htrans_s = 2'b00;
        @(negedge clk);
        d = hrdata_s;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] e;
        int acc_c, acc0;

        tbl[0] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[1] = '{16'h0005, 16'h0003, 16'h0008, 16'h0008};
        tbl[2] = '{16'h0010, 16'hFFFF, 16'h000F, 16'h000F};
        tbl[3] = '{16'h7FF0, 16'h0020, 16'h8010, 16'h7FFF};
        tbl[4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000};
        tbl[5] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000};
        tbl[6] = '{16'h1234, 16'h1111, 16'h2345, 16'h2345};
        tbl[7] = '{16'h8001, 16'h8001, 16'h0002, 16'h8000};

        reset = 1'b1;
        tvalid_s = 0; tlast_s = 0; tdata_s = 0;
        haddr_s = 0; htrans_s = 0; hwrite_s = 0; hsize_s = 0; hwdata_s = 0; hready_s = 1;
        #2;
        check("rst_tvalid_m", tvalid_m, 0);
        check("rst_tlast_m", tlast_m, 0);
        check("rst_tdata_m", tdata_m, 0);
        check("rst_hresp", hresp_s, 0);
        check("rst_hrdata", hrdata_s, 0);
        check("rst_hreadyout", hreadyout_s, 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_tready_s", tready_s, 1);
        ahb_read(32'h800, rd); check("rst_ctrl", rd, 0);
        ahb_read(32'h804, rd); check("rst_frames", rd, 0);

        // Table of sample/coefficient pairs, one 8-beat frame
        for (int i = 0; i < 8; i++) ahb_write(32'(i * 2), {16'h0, tbl[i].coef}, 3'b001);
        for (int i = 0; i < 8; i++) begin
`ifdef TX_COMP_SATURATE_EN
            e = tbl[i].exp_sat;
`else
            e = tbl[i].exp_wrap;
`endif
            send_beat(tbl[i].din, i == 7, e, acc_c);
        end
        drain("tbl_drain");
        ahb_read(32'h006, rd); check("rd_coef3", rd, 32'h0000_0020);
        ahb_read(32'h004, rd); check("rd_coef2_low", rd[15:0], 16'hFFFF);

        // Ramp coefficients, one no-stall 1024-beat frame
        pulse_reset();
        for (int i = 0; i < 1024; i++) ahb_write(32'(i * 2), 32'(i), 3'b001);
        first_vld_c = -1; lat_arm = 1;
        send_beat(16'd100, 1'b0, 16'd100, acc0);
        for (int i = 1; i < 1024; i++) send_beat(16'd100, i == 1023, 16'(100 + i), acc_c);
        drain("ramp_drain");
        lat_arm = 0;
        check("first_latency", first_vld_c - acc0, 2);
        ahb_read(32'h804, rd); check("frames_1", rd, 1);

        // Same frames under random output backpressure
        pulse_reset();
        rand_mode = 1;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 1024; i++) send_beat(16'd100, i == 1023, 16'(100 + i), acc_c);
        drain("stall_drain");
        rand_mode = 0;
        @(posedge clk); #1;
        ahb_read(32'h804, rd); check("frames_3", rd, 3);

        // AHB write to coeff 8 lands on the edge that reads coeff 8 for the stream
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                tvalid_s = 1'b1; tdata_s = 16'h0; tlast_s = (i == 15);
                if (f == 0 && i == 7) begin
                    haddr_s = 32'h010; htrans_s = 2'b10; hwrite_s = 1'b1; hsize_s = 3'b001;
                end else if (f == 0 && i == 8) begin
                    htrans_s = 2'b00; hwrite_s = 1'b0; hwdata_s = 32'h1234;
                end
                @(negedge clk);
                check("rf_tready_s", tready_s, 1);
                e = (i == 8) ? ((f == 0) ? 16'd8 : 16'h1234) : 16'(i);
                exp_q.push_back({tlast_s, e});
                @(posedge clk); #1;
            end
        end
        tvalid_s = 1'b0; tlast_s = 1'b0;
        drain("rf_drain");
        ahb_read(32'h010, rd); check("rd_coef8", rd, 32'h0000_1234);

        // Oversized transfer: two-cycle ERROR, no write
        haddr_s = 32'h010; htrans_s = 2'b10; hwrite_s = 1'b1; hsize_s = 3'b011;
        @(posedge clk); #1;
        htrans_s = 2'b00; hwrite_s = 1'b0; hwdata_s = 32'hBEEF;
        @(negedge clk);
        check("err1_resp", {hresp_s, hreadyout_s}, 2'b10);
        @(posedge clk); #1;
        @(negedge clk);
        check("err2_resp", {hresp_s, hreadyout_s}, 2'b11);
        @(posedge clk); #1;
        @(negedge clk);
        check("err_done", {hresp_s, hreadyout_s}, 2'b01);
        @(posedge clk); #1;
        ahb_read(32'h010, rd); check("err_no_write", rd, 32'h0000_1234);

        // Unmapped address and bypass
        ahb_write(32'h900, 32'hFFFF_FFFF, 3'b010);
        ahb_read(32'h900, rd); check("unmapped_rd", rd, 0);
        ahb_write(32'h800, 32'h1, 3'b010);
        ahb_read(32'h800, rd); check("ctrl_bypass", rd, 1);
        send_beat(16'h7FF0, 1'b0, 16'h7FF0, acc_c);
        send_beat(16'h0001, 1'b0, 16'h0001, acc_c);
        send_beat(16'h8000, 1'b0, 16'h8000, acc_c);
        send_beat(16'hABCD, 1'b1, 16'hABCD, acc_c);
        drain("bypass_drain");
        ahb_write(32'h800, 32'h0, 3'b010);
        ahb_read(32'h804, rd); check("frames_6", rd, 6);

        // Reset in the middle of a frame
        for (int i = 0; i < 500; i++)
            send_beat(16'd100, 1'b0, 16'(100 + ((i == 8) ? 16'h1234 : 16'(i))), acc_c);
        check("pre_reset_vld", tvalid_m, 1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("reset_vld_now", tvalid_m, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send_beat(16'd100, 1'b1, 16'd100, acc_c);
        drain("post_reset_drain");

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
